uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart_tx transmitter between NUM_REQ byte-stream requesters.
//   Each requester offers a packet (bytes + last flag) on valid/ready. The
//   block grants round-robin, holds the grant for a whole packet (bounded by
//   MAX_BURST), and sequences uart_tx through its trigger/busy handshake.
//   It sits between protocol/string sources (loopback buffer, status
//   reporters) and the single physical TX line.
// PARAMETERS
//   NUM_REQ      4   number of requesters (>=1); requester 0 = lowest index
//   DATA_WIDTH   8   byte width, matches uart_tx data_in
//   MAX_BURST    32  max bytes per grant before forced re-arbitration (>=1)
//   BUSY_TIMEOUT 4   cycles to wait for tx_busy to rise after a trigger (>=1)
// PORTS
//   clk          in   1                      system clock
//   rst          in   1                      async reset, active-high
//   req_valid    in   NUM_REQ                per-requester byte valid
//   req_data     in   NUM_REQ*DATA_WIDTH     requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     in   NUM_REQ                byte is last of packet (sampled with req_data)
//   req_ready    out  NUM_REQ                one-hot byte accept, combinational
//   tx_trigger   out  1                      one-cycle start pulse to uart_tx
//   tx_data      out  DATA_WIDTH             byte to uart_tx; stable while busy
//   tx_busy      in   1                      uart_tx busy
//   grant_id     out  max(1,$clog2(NUM_REQ)) current/last granted requester
//   grant_active out  1                      a grant is held
//   sent_count   out  32                     total bytes triggered, wraps 2^32-1 -> 0
// BEHAVIOUR
//   Reset (rst=1, async): FSM=IDLE; req_ready=0, tx_trigger=0, tx_data=0,
//     grant_id=0, grant_active=0, sent_count=0, rr pointer = NUM_REQ-1
//     (so requester 0 wins first). Mid-packet reset drops the grant; the
//     partial packet is not resumed.
//   FSM states: IDLE, SEND, WAIT_HI, WAIT_LO.
//   IDLE: if any req_valid and !tx_busy: pick first valid index after rr
//     pointer (wrapping modulo NUM_REQ); next cycle grant_id=winner,
//     grant_active=1, burst_cnt=0, state=SEND. No valid: stay IDLE.
//   SEND: req_ready[grant_id] = req_valid[grant_id] & !tx_busy (others 0).
//     On accept (valid&ready): tx_data<=req_data[grant_id], last_q<=req_last,
//     burst_cnt+1, sent_count+1, tx_trigger=1 next cycle only, ->WAIT_HI.
//     Granted valid low: hold grant, wait (no pre-emption).
//   WAIT_HI: leave to WAIT_LO when tx_busy=1, or after BUSY_TIMEOUT cycles
//     without busy (byte treated as sent). tx_trigger=0 here.
//   WAIT_LO: when tx_busy=0: if last_q or burst_cnt==MAX_BURST -> IDLE,
//     grant_active=0, rr pointer=grant_id; else -> SEND.
//   Latency: grant-to-trigger >= 2 cycles; accept-to-trigger 1 cycle.
//   At most one req_ready high per cycle; never two triggers without an
//     intervening WAIT_LO exit. tx_data changes only on accept.
//   Simultaneous valid on all requesters: strict round-robin, each gets one
//     packet (or MAX_BURST bytes) in turn. NUM_REQ=1: same FSM, no rotation.
//   MAX_BURST cut mid-packet: requester is re-arbitrated later and continues
//     with its next byte; packet boundaries on TX interleave only at cuts.
//   rr pointer and burst_cnt wrap cleanly; burst_cnt width $clog2(MAX_BURST+1).
// TESTING
//   1. Reset then req0 sends 3 bytes 0x41,0x42,0x43(last), uart_tx model busy
//      10 cycles -> 3 trigger pulses, tx_data in order, sent_count=3, IDLE.
//   2. req0..req3 all valid, 2-byte packets -> grant order 0,1,2,3, 8 bytes
//      never interleaved within a packet, sent_count=8.
//   3. MAX_BURST=4, req1 5-byte packet, req2 1-byte packet -> bytes 1..4 of
//      req1, req2 byte, req1 byte 5; grant_active drops between grants.
//   4. busy never rises (stub tied 0) -> each byte exits WAIT_HI after
//      BUSY_TIMEOUT=4 cycles; trigger spacing = 1+4+1 cycles, no hang.
//   5. rst asserted during WAIT_LO of byte 2 of 4 -> all outputs reset value
//      same cycle, next grant goes to requester 0, sent_count restarts at 0.
//   6. Granted req3 drops valid for 20 cycles mid-packet, req0 valid ->
//      grant stays 3, req_ready[0]=0 throughout, resumes when req3 valid.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, uart_tx handshake and arbiter status for uart_tx_arbiter.
// The arbiter connects through the slave modport; sources and the uart_tx side use master.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8
);
   localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          tx_trigger;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_busy;
   logic [IdW-1:0]                grant_id;
   logic                          grant_active;
   logic [31:0]                   sent_count;

   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_trigger, tx_data, grant_id, grant_active, sent_count
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_trigger, tx_data, grant_id, grant_active, sent_count
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ packet requesters.
// A grant is held for a whole packet (at most MAX_BURST bytes) and sequences trigger/busy.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned MAX_BURST    = 32,
   parameter int unsigned BUSY_TIMEOUT = 4
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
   localparam int unsigned TmoW   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

   typedef enum logic [1:0] {StIdle, StSend, StWaitHi, StWaitLo} state_e;

   state_e                r_state, w_state_d;
   logic [IdW-1:0]        r_grant_id, w_grant_id_d;
   logic [IdW-1:0]        r_rr_ptr, w_rr_ptr_d;
   logic                  r_grant_active, w_grant_active_d;
   logic [BurstW-1:0]     r_burst_cnt, w_burst_cnt_d;
   logic [TmoW-1:0]       r_tmo_cnt, w_tmo_cnt_d;
   logic                  r_last, w_last_d;
   logic                  r_tx_trigger, w_tx_trigger_d;
   logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_d;
   logic [31:0]           r_sent_count, w_sent_count_d;

   logic [IdW-1:0]        w_idx;
   logic [IdW-1:0]        w_winner;
   logic                  w_any_valid;
   logic [NUM_REQ-1:0]    w_req_ready;

   // First valid requester strictly after the rr pointer, wrapping.
   always_comb begin
      w_idx       = '0;
      w_winner    = '0;
      w_any_valid = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_idx = IdW'((32'(r_rr_ptr) + k) % NUM_REQ);
         if (!w_any_valid && bus.req_valid[w_idx]) begin
            w_any_valid = 1'b1;
            w_winner    = w_idx;
         end
      end
   end

   always_comb begin
      w_state_d        = r_state;
      w_grant_id_d     = r_grant_id;
      w_rr_ptr_d       = r_rr_ptr;
      w_grant_active_d = r_grant_active;
      w_burst_cnt_d    = r_burst_cnt;
      w_tmo_cnt_d      = r_tmo_cnt;
      w_last_d         = r_last;
      w_tx_trigger_d   = 1'b0;
      w_tx_data_d      = r_tx_data;
      w_sent_count_d   = r_sent_count;
      w_req_ready      = '0;

      unique case (r_state)
         StIdle: begin
            if (w_any_valid && !bus.tx_busy) begin
               w_grant_id_d     = w_winner;
               w_grant_active_d = 1'b1;
               w_burst_cnt_d    = '0;
               w_state_d        = StSend;
            end
         end
         StSend: begin
            w_req_ready[r_grant_id] = bus.req_valid[r_grant_id] & ~bus.tx_busy;
            if (w_req_ready[r_grant_id]) begin
               w_tx_data_d    = bus.req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
               w_last_d       = bus.req_last[r_grant_id];
               w_burst_cnt_d  = r_burst_cnt + 1'b1;
               w_sent_count_d = r_sent_count + 32'd1;
               w_tx_trigger_d = 1'b1;
               w_tmo_cnt_d    = '0;
               w_state_d      = StWaitHi;
            end
         end
         StWaitHi: begin
            // A uart_tx that never reports busy is treated as having taken the byte.
            if (bus.tx_busy || r_tmo_cnt == TmoW'(BUSY_TIMEOUT - 1)) begin
               w_state_d = StWaitLo;
            end else begin
               w_tmo_cnt_d = r_tmo_cnt + 1'b1;
            end
         end
         StWaitLo: begin
            if (!bus.tx_busy) begin
               if (r_last || r_burst_cnt == BurstW'(MAX_BURST)) begin
                  w_grant_active_d = 1'b0;
                  w_rr_ptr_d       = r_grant_id;
                  w_state_d        = StIdle;
               end else begin
                  w_state_d = StSend;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= StIdle;
         r_grant_id     <= '0;
         r_rr_ptr       <= IdW'(NUM_REQ - 1);
         r_grant_active <= 1'b0;
         r_burst_cnt    <= '0;
         r_tmo_cnt      <= '0;
         r_last         <= 1'b0;
         r_tx_trigger   <= 1'b0;
         r_tx_data      <= '0;
         r_sent_count   <= '0;
      end else begin
         r_state        <= w_state_d;
         r_grant_id     <= w_grant_id_d;
         r_rr_ptr       <= w_rr_ptr_d;
         r_grant_active <= w_grant_active_d;
         r_burst_cnt    <= w_burst_cnt_d;
         r_tmo_cnt      <= w_tmo_cnt_d;
         r_last         <= w_last_d;
         r_tx_trigger   <= w_tx_trigger_d;
         r_tx_data      <= w_tx_data_d;
         r_sent_count   <= w_sent_count_d;
      end
   end

   assign bus.req_ready    = w_req_ready;
   assign bus.tx_trigger   = r_tx_trigger;
   assign bus.tx_data      = r_tx_data;
   assign bus.grant_id     = r_grant_id;
   assign bus.grant_active = r_grant_active;
   assign bus.sent_count   = r_sent_count;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued packet sources, a uart_tx busy model, and a
// packet-level round-robin reference that predicts the byte order on the TX line.
module tb_uart_tx_arbiter;
   localparam int NR  = 4;
   localparam int DW  = 8;
   localparam int MB  = 4;
   localparam int TMO = 4;
   localparam int IW  = 2;

   logic clk;
   logic rst;

   uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .BUSY_TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int            n_vec;
   int            n_err;
   int            cyc;
   logic [8:0]    srcq [NR][$];
   logic [8:0]    mq [NR][$];
   logic [NR-1:0] hold;
   logic [DW-1:0] exp_byte[$];
   logic [IW-1:0] exp_id[$];
   logic [DW-1:0] trig_byte[$];
   logic [IW-1:0] trig_id[$];
   int            trig_cyc[$];
   int            acc_cyc[$];
   int            busy_len;
   int            busy_cnt;
   int            grants_seen;
   int            exp_grants;
   int            m_rr;
   logic          prev_ga;
   logic [DW-1:0] last_trig_data;
   logic [31:0]   exp_sent;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drive_sources();
      logic [NR-1:0]    v;
      logic [NR-1:0]    l;
      logic [NR*DW-1:0] d;
      logic [8:0]       h;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < NR; i++) begin
         if (srcq[i].size() > 0 && !hold[i]) begin
            h = srcq[i][0];
            v[i] = 1'b1;
            l[i] = h[8];
            d[i*DW +: DW] = h[DW-1:0];
         end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
   endtask

   // One clock: monitor + uart model at negedge, accept sampling just before posedge.
   task automatic step();
      int         acc;
      logic [8:0] h;
      @(negedge clk);
      if (bus.tx_trigger) begin
         trig_byte.push_back(bus.tx_data);
         trig_id.push_back(bus.grant_id);
         trig_cyc.push_back(cyc);
         last_trig_data = bus.tx_data;
      end else if (bus.tx_busy) begin
         n_vec++;
         if (bus.tx_data !== last_trig_data) begin
            n_err++;
            $display("FAIL tx_data_stable cyc %0d: got %h expected %h", cyc, bus.tx_data,
                     last_trig_data);
         end
      end
      if (bus.grant_active && !prev_ga) grants_seen++;
      prev_ga = bus.grant_active;
      if (bus.tx_trigger && busy_len > 0) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      bus.tx_busy = (busy_cnt != 0);
      #4;
      acc = -1;
      n_vec++;
      if ($countones(bus.req_ready) > 1) begin
         n_err++;
         $display("FAIL ready_onehot cyc %0d: got %b expected at most one bit", cyc,
                  bus.req_ready);
      end
      for (int i = 0; i < NR; i++) if (bus.req_valid[i] && bus.req_ready[i]) acc = i;
      @(posedge clk);
      #1;
      cyc++;
      if (acc >= 0) begin
         h = srcq[acc].pop_front();
         acc_cyc.push_back(cyc);
      end
      drive_sources();
   endtask

   task automatic clear_records();
      trig_byte.delete();
      trig_id.delete();
      trig_cyc.delete();
      acc_cyc.delete();
      exp_byte.delete();
      exp_id.delete();
      grants_seen = 0;
      exp_grants  = 0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      hold = '0;
      for (int i = 0; i < NR; i++) begin
         srcq[i].delete();
         mq[i].delete();
      end
      busy_cnt = 0;
      bus.tx_busy = 1'b0;
      last_trig_data = '0;
      drive_sources();
      repeat (2) step();
      rst = 1'b0;
      m_rr = NR - 1;
      exp_sent = '0;
      clear_records();
   endtask

   // Packet-level reference: whole packets round-robin, cut after MB bytes.
   task automatic model_run();
      int         w;
      int         n;
      logic [8:0] b;
      bit         done;
      done = 1'b0;
      while (!done) begin
         w = -1;
         for (int k = 1; k <= NR; k++) begin
            if (w < 0 && mq[(m_rr + k) % NR].size() > 0) w = (m_rr + k) % NR;
         end
         if (w < 0) begin
            done = 1'b1;
         end else begin
            exp_grants++;
            n = 0;
            do begin
               b = mq[w].pop_front();
               exp_id.push_back(IW'(w));
               exp_byte.push_back(b[DW-1:0]);
               exp_sent = exp_sent + 32'd1;
               n++;
            end while (!b[8] && n < MB);
            m_rr = w;
         end
      end
   endtask

   task automatic load_byte(input int id, input logic [DW-1:0] data, input logic last);
      srcq[id].push_back({last, data});
      mq[id].push_back({last, data});
      drive_sources();
   endtask

   task automatic load_pkt(input int id, input int len);
      for (int j = 0; j < len; j++) begin
         load_byte(id, DW'($urandom_range(0, 255)), (j == len - 1));
      end
   endtask

   function automatic bit sources_pending();
      for (int i = 0; i < NR; i++) if (srcq[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic run_until_idle(input string name, input int budget);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while ((sources_pending() || bus.grant_active || busy_cnt != 0) && n < budget);
      n_vec++;
      if (sources_pending() || bus.grant_active || busy_cnt != 0) begin
         n_err++;
         $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
      end
   endtask

   task automatic check_stream(input string name);
      n_vec++;
      if (trig_byte.size() != exp_byte.size()) begin
         n_err++;
         $display("FAIL %s_count: got %0d triggers expected %0d", name, trig_byte.size(),
                  exp_byte.size());
      end
      for (int i = 0; i < trig_byte.size() && i < exp_byte.size(); i++) begin
         n_vec++;
         if (trig_byte[i] !== exp_byte[i] || trig_id[i] !== exp_id[i]) begin
            n_err++;
            $display("FAIL %s_byte%0d: got id %0d data %h expected id %0d data %h", name, i,
                     trig_id[i], trig_byte[i], exp_id[i], exp_byte[i]);
         end
      end
      n_vec++;
      if (acc_cyc.size() != trig_cyc.size()) begin
         n_err++;
         $display("FAIL %s_accepts: got %0d accepts expected %0d", name, acc_cyc.size(),
                  trig_cyc.size());
      end
      for (int i = 0; i < acc_cyc.size() && i < trig_cyc.size(); i++) begin
         n_vec++;
         if (trig_cyc[i] !== acc_cyc[i]) begin
            n_err++;
            $display("FAIL %s_latency%0d: got trigger cyc %0d expected %0d", name, i,
                     trig_cyc[i], acc_cyc[i]);
         end
      end
      n_vec++;
      if (grants_seen != exp_grants) begin
         n_err++;
         $display("FAIL %s_grants: got %0d expected %0d", name, grants_seen, exp_grants);
      end
      n_vec++;
      if (bus.sent_count !== exp_sent) begin
         n_err++;
         $display("FAIL %s_sent_count: got %0d expected %0d", name, bus.sent_count, exp_sent);
      end
      n_vec++;
      if (bus.grant_id !== IW'(m_rr) || bus.grant_active !== 1'b0) begin
         n_err++;
         $display("FAIL %s_final_grant: got id %0d active %b expected id %0d active 0", name,
                  bus.grant_id, bus.grant_active, m_rr);
      end
      clear_records();
   endtask

   task automatic check_reset_outputs(input string name);
      n_vec++;
      if (bus.req_ready !== '0 || bus.tx_trigger !== 1'b0 || bus.tx_data !== '0) begin
         n_err++;
         $display("FAIL %s_handshake: got ready %b trig %b data %h expected 0 0 00", name,
                  bus.req_ready, bus.tx_trigger, bus.tx_data);
      end
      n_vec++;
      if (bus.grant_id !== '0 || bus.grant_active !== 1'b0) begin
         n_err++;
         $display("FAIL %s_grant: got id %0d active %b expected 0 0", name, bus.grant_id,
                  bus.grant_active);
      end
      n_vec++;
      if (bus.sent_count !== 32'd0) begin
         n_err++;
         $display("FAIL %s_sent_count: got %0d expected 0", name, bus.sent_count);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      check_reset_outputs("reset");
   endtask

   task automatic test_single_packet();
      apply_reset();
      busy_len = 10;
      load_byte(0, 8'h41, 1'b0);
      load_byte(0, 8'h42, 1'b0);
      load_byte(0, 8'h43, 1'b1);
      model_run();
      run_until_idle("single", 500);
      check_stream("single");
   endtask

   task automatic test_all_requesters();
      apply_reset();
      busy_len = $urandom_range(1, 5);
      for (int i = 0; i < NR; i++) load_pkt(i, 2);
      model_run();
      run_until_idle("all_req", 1000);
      check_stream("all_req");
   endtask

   task automatic test_burst_cut();
      apply_reset();
      busy_len = 2;
      load_pkt(1, 5);
      load_pkt(2, 1);
      model_run();
      run_until_idle("burst_cut", 1000);
      check_stream("burst_cut");
   endtask

   task automatic test_busy_timeout();
      busy_len = 0;
      load_pkt(2, 3);
      model_run();
      run_until_idle("timeout", 500);
      for (int i = 1; i < trig_cyc.size(); i++) begin
         n_vec++;
         if (trig_cyc[i] - trig_cyc[i-1] != 1 + TMO + 1) begin
            n_err++;
            $display("FAIL timeout_spacing%0d: got %0d cycles expected %0d", i,
                     trig_cyc[i] - trig_cyc[i-1], 1 + TMO + 1);
         end
      end
      check_stream("timeout");
   endtask

   task automatic test_reset_mid_packet();
      int n;
      apply_reset();
      busy_len = 10;
      load_pkt(1, 4);
      n = 0;
      while (trig_byte.size() < 2 && n < 500) begin
         step();
         n++;
      end
      n_vec++;
      if (trig_byte.size() < 2) begin
         n_err++;
         $display("FAIL midrst_wait: got %0d triggers expected 2", trig_byte.size());
      end
      repeat (3) step();
      n_vec++;
      if (bus.grant_active !== 1'b1 || bus.grant_id !== 2'd1) begin
         n_err++;
         $display("FAIL midrst_pre: got id %0d active %b expected 1 1", bus.grant_id,
                  bus.grant_active);
      end
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      apply_reset();
      busy_len = 3;
      load_pkt(1, 2);
      load_pkt(0, 1);
      model_run();
      run_until_idle("post_rst", 500);
      check_stream("post_rst");
   endtask

   task automatic test_stall_hold();
      int n;
      apply_reset();
      busy_len = 3;
      load_pkt(3, 4);
      model_run();
      n = 0;
      while (trig_byte.size() < 2 && n < 500) begin
         step();
         n++;
      end
      n_vec++;
      if (trig_byte.size() < 2) begin
         n_err++;
         $display("FAIL stall_wait: got %0d triggers expected 2", trig_byte.size());
      end
      hold[3] = 1'b1;
      load_pkt(0, 2);
      model_run();
      for (int c = 0; c < 20; c++) begin
         step();
         n_vec++;
         if (bus.req_ready[0] !== 1'b0 || bus.grant_id !== 2'd3 || bus.grant_active !== 1'b1)
         begin
            n_err++;
            $display("FAIL stall_hold cyc %0d: got ready0 %b id %0d active %b expected 0 3 1",
                     c, bus.req_ready[0], bus.grant_id, bus.grant_active);
         end
      end
      hold[3] = 1'b0;
      drive_sources();
      run_until_idle("stall", 1000);
      check_stream("stall");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         busy_len = $urandom_range(0, 6);
         for (int p = 0; p < int'($urandom_range(1, 6)); p++) begin
            load_pkt($urandom_range(0, NR - 1), $urandom_range(1, 7));
         end
         model_run();
         run_until_idle("random", 3000);
         check_stream("random");
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      cyc = 0;
      busy_len = 0;
      prev_ga = 1'b0;
      rst = 1'b1;
      hold = '0;
      bus.tx_busy = 1'b0;
      drive_sources();
      test_reset();
      test_single_packet();
      test_all_requesters();
      test_burst_cut();
      test_busy_timeout();
      test_reset_mid_packet();
      test_stall_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
